// File: rtl/decode_pipe_if.sv
// Fetch -> decode -> execute bundle for decode_pipe, including the regfile read port.
// The slave modport is the decode stage; master is whatever surrounds it.
interface decode_pipe_if #(
    parameter int XLEN          = 32,
    parameter int REG_IDX_WIDTH = 5,
    parameter int PC_WIDTH      = 32,
    parameter int CNT_WIDTH     = 32
) ();
    logic                     flush_i;
    logic                     if_valid_i;
    logic                     if_ready_o;
    logic [31:0]              if_instr_i;
    logic [PC_WIDTH-1:0]      if_pc_i;
    logic [REG_IDX_WIDTH-1:0] dec_rs1_idx_o;
    logic [REG_IDX_WIDTH-1:0] dec_rs2_idx_o;
    logic                     dec_rs1_en;
    logic                     dec_rs2_en;
    logic [XLEN-1:0]          dec_rs1_i;
    logic [XLEN-1:0]          dec_rs2_i;
    logic                     ex_valid_o;
    logic                     ex_ready_i;
    logic [PC_WIDTH-1:0]      ex_pc_o;
    logic [XLEN-1:0]          ex_rs1_o;
    logic [XLEN-1:0]          ex_rs2_o;
    logic [XLEN-1:0]          ex_imm_o;
    logic [REG_IDX_WIDTH-1:0] ex_rd_idx_o;
    logic                     ex_rd_en_o;
    logic [3:0]               ex_op_o;
    logic [2:0]               ex_fun3_o;
    logic                     ex_alt_o;
    logic                     ex_illegal_o;
    logic [CNT_WIDTH-1:0]     dec_cnt_o;

    modport slave (
        input  flush_i, if_valid_i, if_instr_i, if_pc_i, dec_rs1_i, dec_rs2_i, ex_ready_i,
        output if_ready_o, dec_rs1_idx_o, dec_rs2_idx_o, dec_rs1_en, dec_rs2_en,
               ex_valid_o, ex_pc_o, ex_rs1_o, ex_rs2_o, ex_imm_o, ex_rd_idx_o, ex_rd_en_o,
               ex_op_o, ex_fun3_o, ex_alt_o, ex_illegal_o, dec_cnt_o
    );

    modport master (
        output flush_i, if_valid_i, if_instr_i, if_pc_i, dec_rs1_i, dec_rs2_i, ex_ready_i,
        input  if_ready_o, dec_rs1_idx_o, dec_rs2_idx_o, dec_rs1_en, dec_rs2_en,
               ex_valid_o, ex_pc_o, ex_rs1_o, ex_rs2_o, ex_imm_o, ex_rd_idx_o, ex_rd_en_o,
               ex_op_o, ex_fun3_o, ex_alt_o, ex_illegal_o, dec_cnt_o
    );
endinterface

// File: rtl/decode_pipe.sv
// RV32I(+M) decode stage: combinational crack of the fetched word, regfile index drive,
// and a single valid/ready output register towards execute with flush and a decode counter.
module decode_pipe #(
    parameter int XLEN           = 32,
    parameter int REG_IDX_WIDTH  = 5,
    parameter int PC_WIDTH       = 32,
    parameter int EN_M_EXT       = 1,
    parameter int RD_X0_SUPPRESS = 1,
    parameter int CNT_WIDTH      = 32
) (
    input logic         clk,
    input logic         rst_n,
    decode_pipe_if.slave bus
);
    typedef enum logic [3:0] {
        OPC_LUI      = 4'd0,
        OPC_AUIPC    = 4'd1,
        OPC_JAL      = 4'd2,
        OPC_JALR     = 4'd3,
        OPC_BRANCH   = 4'd4,
        OPC_LOAD     = 4'd5,
        OPC_STORE    = 4'd6,
        OPC_OP_IMM   = 4'd7,
        OPC_OP       = 4'd8,
        OPC_MISC_MEM = 4'd9,
        OPC_SYSTEM   = 4'd10,
        OPC_MULDIV   = 4'd11,
        OPC_ILLEGAL  = 4'd15
    } op_e;

    localparam bit SHAMT6 = (XLEN == 64);

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  fun3;
    logic [6:0]  fun7;
    logic [4:0]  rd_field;

    assign instr    = bus.if_instr_i;
    assign opcode   = instr[6:0];
    assign fun3     = instr[14:12];
    assign fun7     = instr[31:25];
    assign rd_field = instr[11:7];

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    assign imm_i = {{(XLEN-11){instr[31]}}, instr[30:20]};
    assign imm_s = {{(XLEN-11){instr[31]}}, instr[30:25], instr[11:7]};
    assign imm_b = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};
    assign imm_j = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

    // On RV64 instr[25] is shamt[5], so it is not part of the funct7 legality check.
    logic shamt_hi_ok, sra_hi_ok;
    assign shamt_hi_ok = (instr[31:26] == 6'b000000) && (SHAMT6 || !instr[25]);
    assign sra_hi_ok   = (instr[31:26] == 6'b010000) && (SHAMT6 || !instr[25]);

    op_e             op_c;
    logic [XLEN-1:0] imm_c;
    logic            rs1_en_c, rs2_en_c, rd_use_c, rd_en_c, alt_c, illegal_c;

    always_comb begin
        op_c      = OPC_ILLEGAL;
        imm_c     = '0;
        rs1_en_c  = 1'b0;
        rs2_en_c  = 1'b0;
        rd_use_c  = 1'b0;
        alt_c     = 1'b0;
        illegal_c = 1'b0;
        case (opcode)
            7'b0110111: begin op_c = OPC_LUI;   imm_c = imm_u; rd_use_c = 1'b1; end
            7'b0010111: begin op_c = OPC_AUIPC; imm_c = imm_u; rd_use_c = 1'b1; end
            7'b1101111: begin op_c = OPC_JAL;   imm_c = imm_j; rd_use_c = 1'b1; end
            7'b1100111: begin
                op_c = OPC_JALR; imm_c = imm_i; rs1_en_c = 1'b1; rd_use_c = 1'b1;
                illegal_c = (fun3 != 3'b000);
            end
            7'b1100011: begin
                op_c = OPC_BRANCH; imm_c = imm_b; rs1_en_c = 1'b1; rs2_en_c = 1'b1;
                illegal_c = (fun3 == 3'b010) || (fun3 == 3'b011);
            end
            7'b0000011: begin
                op_c = OPC_LOAD; imm_c = imm_i; rs1_en_c = 1'b1; rd_use_c = 1'b1;
                illegal_c = (fun3 == 3'b011) || (fun3 == 3'b110) || (fun3 == 3'b111);
            end
            7'b0100011: begin
                op_c = OPC_STORE; imm_c = imm_s; rs1_en_c = 1'b1; rs2_en_c = 1'b1;
                illegal_c = (fun3 >= 3'b011);
            end
            7'b0010011: begin
                op_c = OPC_OP_IMM; imm_c = imm_i; rs1_en_c = 1'b1; rd_use_c = 1'b1;
                if (fun3 == 3'b001) begin
                    illegal_c = !shamt_hi_ok;
                end else if (fun3 == 3'b101) begin
                    illegal_c = !(shamt_hi_ok || sra_hi_ok);
                    alt_c     = instr[30];
                end
            end
            7'b0110011: begin
                op_c = OPC_OP; rs1_en_c = 1'b1; rs2_en_c = 1'b1; rd_use_c = 1'b1;
                alt_c = instr[30];
                case (fun7)
                    7'b0000000: illegal_c = 1'b0;
                    7'b0100000: illegal_c = !((fun3 == 3'b000) || (fun3 == 3'b101));
                    7'b0000001: begin
                        op_c      = OPC_MULDIV;
                        illegal_c = (EN_M_EXT == 0);
                    end
                    default:    illegal_c = 1'b1;
                endcase
            end
            7'b0001111: op_c = OPC_MISC_MEM;
            7'b1110011: begin
                op_c     = OPC_SYSTEM;
                imm_c    = imm_i;
                rs1_en_c = (fun3 == 3'b001) || (fun3 == 3'b010) || (fun3 == 3'b011);
                rd_use_c = (fun3 != 3'b000);
            end
            default: illegal_c = 1'b1;
        endcase
        if (instr[1:0] != 2'b11) begin
            illegal_c = 1'b1;
        end
        // An illegal word must not touch the regfile or carry an operand downstream.
        if (illegal_c) begin
            op_c     = OPC_ILLEGAL;
            imm_c    = '0;
            rs1_en_c = 1'b0;
            rs2_en_c = 1'b0;
            rd_use_c = 1'b0;
            alt_c    = 1'b0;
        end
    end

    assign rd_en_c = rd_use_c && !((RD_X0_SUPPRESS != 0) && (rd_field == 5'd0));

    assign bus.dec_rs1_idx_o = REG_IDX_WIDTH'(instr[19:15]);
    assign bus.dec_rs2_idx_o = REG_IDX_WIDTH'(instr[24:20]);
    assign bus.dec_rs1_en    = rs1_en_c;
    assign bus.dec_rs2_en    = rs2_en_c;

    logic                     valid_reg;
    logic [PC_WIDTH-1:0]      pc_reg;
    logic [XLEN-1:0]          rs1_reg, rs2_reg, imm_reg;
    logic [REG_IDX_WIDTH-1:0] rd_idx_reg;
    logic                     rd_en_reg, alt_reg, illegal_reg;
    logic [3:0]               op_reg;
    logic [2:0]               fun3_reg;
    logic [CNT_WIDTH-1:0]     cnt_reg;
    logic                     if_ready, accept;

    assign if_ready = bus.flush_i || !valid_reg || bus.ex_ready_i;
    assign accept   = bus.if_valid_i && if_ready && !bus.flush_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_reg   <= 1'b0;
            pc_reg      <= '0;
            rs1_reg     <= '0;
            rs2_reg     <= '0;
            imm_reg     <= '0;
            rd_idx_reg  <= '0;
            rd_en_reg   <= 1'b0;
            op_reg      <= '0;
            fun3_reg    <= '0;
            alt_reg     <= 1'b0;
            illegal_reg <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            if (accept) begin
                valid_reg   <= 1'b1;
                pc_reg      <= bus.if_pc_i;
                rs1_reg     <= rs1_en_c ? bus.dec_rs1_i : '0;
                rs2_reg     <= rs2_en_c ? bus.dec_rs2_i : '0;
                imm_reg     <= imm_c;
                rd_idx_reg  <= REG_IDX_WIDTH'(rd_field);
                rd_en_reg   <= rd_en_c;
                op_reg      <= op_c;
                fun3_reg    <= fun3;
                alt_reg     <= alt_c;
                illegal_reg <= illegal_c;
            end else if (bus.flush_i || bus.ex_ready_i) begin
                valid_reg <= 1'b0;
            end
            // A handshake completes even when a flush lands in the same cycle.
            if (valid_reg && bus.ex_ready_i) begin
                cnt_reg <= cnt_reg + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.if_ready_o   = if_ready;
    assign bus.ex_valid_o   = valid_reg;
    assign bus.ex_pc_o      = pc_reg;
    assign bus.ex_rs1_o     = rs1_reg;
    assign bus.ex_rs2_o     = rs2_reg;
    assign bus.ex_imm_o     = imm_reg;
    assign bus.ex_rd_idx_o  = rd_idx_reg;
    assign bus.ex_rd_en_o   = rd_en_reg;
    assign bus.ex_op_o      = op_reg;
    assign bus.ex_fun3_o    = fun3_reg;
    assign bus.ex_alt_o     = alt_reg;
    assign bus.ex_illegal_o = illegal_reg;
    assign bus.dec_cnt_o    = cnt_reg;
endmodule
